// File: rtl/pipelined_divider_core.sv
// Pipelined restoring divider: one quotient bit per slice, MSB first, with a
// register after every SLICES_PER_STAGE slices, a global stall and signed fix-up.
module pipelined_divider_core #(
    parameter int DIVIDENDLEN      = 16,
    parameter int DIVISORLEN       = 8,
    parameter int SLICES_PER_STAGE = 4,
    parameter int TAGW             = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_signed,
    input  logic [DIVIDENDLEN-1:0] i_dividend,
    input  logic [DIVISORLEN-1:0]  i_divisor,
    input  logic [TAGW-1:0]        i_in_tag,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [DIVIDENDLEN-1:0] o_quotient,
    output logic [DIVISORLEN-1:0]  o_remainder,
    output logic                   o_dbz,
    output logic                   o_ovf,
    output logic [TAGW-1:0]        o_out_tag
);

    localparam int N   = DIVIDENDLEN;
    localparam int M   = DIVISORLEN;
    localparam int S   = SLICES_PER_STAGE;
    localparam int W   = N + M - 1;
    localparam int LAT = (N + S - 1) / S;
    localparam int L   = LAT - 1;

    logic                   r_outValid;
    logic [N-1:0]           r_outQuotient;
    logic [M-1:0]           r_outRemainder;
    logic                   r_outDbz;
    logic                   r_outOvf;
    logic [TAGW-1:0]        r_outTag;

    logic                   w_advance;

    logic                   w_aNeg;
    logic                   w_bNeg;
    logic                   w_inDbz;
    logic                   w_inOvf;
    logic [N-1:0]           w_aMag;
    logic [M-1:0]           w_bMag;

    // Values entering each stage: index 0 is the input port, index s>0 is stage s-1's register.
    logic [W-1:0]           w_stagePr    [LAT];
    logic [N-1:0]           w_stageQ     [LAT];
    logic [M-1:0]           w_stageDiv   [LAT];
    logic                   w_stageValid [LAT];
    logic                   w_stageNegQ  [LAT];
    logic                   w_stageNegR  [LAT];
    logic                   w_stageDbz   [LAT];
    logic                   w_stageOvf   [LAT];
    logic [TAGW-1:0]        w_stageTag   [LAT];

    logic [W-1:0]           w_prIn  [N];
    logic [W-1:0]           w_prOut [N];
    logic [N-1:0]           w_qIn   [N];
    logic [N-1:0]           w_qOut  [N];

    logic [N-1:0]           w_qMag;
    logic [M-1:0]           w_rMag;
    logic [N-1:0]           w_qFinal;
    logic [M-1:0]           w_rFinal;

    assign w_advance  = i_out_ready || !r_outValid;
    assign o_in_ready = w_advance;

    // Negating the most-negative value wraps to itself, which reads as unsigned 2^(N-1).
    always_comb begin
        w_aNeg  = i_in_signed && i_dividend[N-1];
        w_bNeg  = i_in_signed && i_divisor[M-1];
        w_aMag  = w_aNeg ? -i_dividend : i_dividend;
        w_bMag  = w_bNeg ? -i_divisor  : i_divisor;
        w_inDbz = (i_divisor == '0);
        w_inOvf = i_in_signed && (i_dividend == {1'b1, {(N-1){1'b0}}}) && (i_divisor == '1);
    end

    assign w_stagePr[0]    = W'(w_aMag);
    assign w_stageQ[0]     = '0;
    assign w_stageDiv[0]   = w_bMag;
    assign w_stageValid[0] = i_in_valid;
    assign w_stageNegQ[0]  = w_aNeg ^ w_bNeg;
    assign w_stageNegR[0]  = w_aNeg;
    assign w_stageDbz[0]   = w_inDbz;
    assign w_stageOvf[0]   = w_inOvf;
    assign w_stageTag[0]   = i_in_tag;

    generate
        for (genvar i = 0; i < N; i++) begin : gSlice
            localparam int STG = (N - 1 - i) / S;
            logic [W:0] w_diff;

            if (((N - 1 - i) % S) == 0) begin : gHead
                assign w_prIn[i] = w_stagePr[STG];
                assign w_qIn[i]  = w_stageQ[STG];
            end else begin : gChain
                assign w_prIn[i] = w_prOut[i+1];
                assign w_qIn[i]  = w_qOut[i+1];
            end

            // The extra top bit of the difference is the borrow of the trial subtraction.
            assign w_diff     = {1'b0, w_prIn[i]} - {1'b0, (W'(w_stageDiv[STG]) << i)};
            assign w_prOut[i] = w_diff[W] ? w_prIn[i] : w_diff[W-1:0];
            assign w_qOut[i]  = w_qIn[i] | (N'(!w_diff[W]) << i);
        end

        for (genvar s = 0; s < LAT - 1; s++) begin : gStage
            localparam int LO = N - (s + 1) * S;
            logic            r_valid;
            logic [W-1:0]    r_pr;
            logic [N-1:0]    r_q;
            logic [M-1:0]    r_div;
            logic            r_negQ;
            logic            r_negR;
            logic            r_dbz;
            logic            r_ovf;
            logic [TAGW-1:0] r_tag;

            always_ff @(posedge i_clock) begin
                if (!i_reset_n) begin
                    r_valid <= 1'b0;
                end else if (w_advance) begin
                    r_valid <= w_stageValid[s];
                    r_pr    <= w_prOut[LO];
                    r_q     <= w_qOut[LO];
                    r_div   <= w_stageDiv[s];
                    r_negQ  <= w_stageNegQ[s];
                    r_negR  <= w_stageNegR[s];
                    r_dbz   <= w_stageDbz[s];
                    r_ovf   <= w_stageOvf[s];
                    r_tag   <= w_stageTag[s];
                end
            end

            assign w_stagePr[s+1]    = r_pr;
            assign w_stageQ[s+1]     = r_q;
            assign w_stageDiv[s+1]   = r_div;
            assign w_stageValid[s+1] = r_valid;
            assign w_stageNegQ[s+1]  = r_negQ;
            assign w_stageNegR[s+1]  = r_negR;
            assign w_stageDbz[s+1]   = r_dbz;
            assign w_stageOvf[s+1]   = r_ovf;
            assign w_stageTag[s+1]   = r_tag;
        end
    endgenerate

    // After the last slice the partial remainder is below the divisor, so its low bits suffice.
    always_comb begin
        w_qMag   = w_qOut[0];
        w_rMag   = M'(w_prOut[0]);
        w_qFinal = w_stageNegQ[L] ? -w_qMag : w_qMag;
        w_rFinal = w_stageNegR[L] ? -w_rMag : w_rMag;
        if (w_stageDbz[L]) begin
            w_qFinal = '1;
            w_rFinal = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_outValid     <= 1'b0;
            r_outQuotient  <= '0;
            r_outRemainder <= '0;
            r_outDbz       <= 1'b0;
            r_outOvf       <= 1'b0;
            r_outTag       <= '0;
        end else if (w_advance) begin
            r_outValid     <= w_stageValid[L];
            r_outQuotient  <= w_qFinal;
            r_outRemainder <= w_rFinal;
            r_outDbz       <= w_stageDbz[L];
            r_outOvf       <= w_stageOvf[L];
            r_outTag       <= w_stageTag[L];
        end
    end

    assign o_out_valid = r_outValid;
    assign o_quotient  = r_outQuotient;
    assign o_remainder = r_outRemainder;
    assign o_dbz       = r_outDbz;
    assign o_ovf       = r_outOvf;
    assign o_out_tag   = r_outTag;

endmodule

// File: tb/tb_pipelined_divider_core.sv
// Bench for pipelined_divider_core: directed vector table, random stream with
// backpressure against a reference model, stall-fill and mid-flight reset.
module tb_pipelined_divider_core;

    localparam int N   = 16;
    localparam int M   = 8;
    localparam int TW  = 4;
    localparam int LAT = 4;
    localparam int NVEC = 14;

    typedef struct {
        logic [N-1:0]  q;
        logic [M-1:0]  r;
        logic          dbz;
        logic          ovf;
        logic [TW-1:0] tag;
    } ExpT;

    typedef struct {
        logic          sgn;
        logic [N-1:0]  a;
        logic [M-1:0]  b;
        logic [TW-1:0] tag;
        ExpT           exp;
    } VecT;

    logic          clock;
    logic          resetN;
    logic          inValid;
    logic          inReady;
    logic          inSigned;
    logic [N-1:0]  dividend;
    logic [M-1:0]  divisor;
    logic [TW-1:0] inTag;
    logic          outValid;
    logic          outReady;
    logic [N-1:0]  quotient;
    logic [M-1:0]  remainder;
    logic          dbz;
    logic          ovf;
    logic [TW-1:0] outTag;

    int  assertCount = 0;
    int  failCount   = 0;
    ExpT scoreQ[$];
    logic rndReady   = 1'b0;
    logic fixedReady = 1'b1;

    pipelined_divider_core #(
        .DIVIDENDLEN(N), .DIVISORLEN(M), .SLICES_PER_STAGE(4), .TAGW(TW)
    ) dut (
        .i_clock(clock), .i_reset_n(resetN),
        .i_in_valid(inValid), .o_in_ready(inReady), .i_in_signed(inSigned),
        .i_dividend(dividend), .i_divisor(divisor), .i_in_tag(inTag),
        .o_out_valid(outValid), .i_out_ready(outReady),
        .o_quotient(quotient), .o_remainder(remainder),
        .o_dbz(dbz), .o_ovf(ovf), .o_out_tag(outTag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Consumer readiness changes shortly after each rising edge, random or fixed.
    initial outReady = 1'b1;
    always @(posedge clock) begin
        #2;
        outReady = rndReady ? 1'($urandom_range(0, 1)) : fixedReady;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic ExpT refModel(input logic sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                                     input logic [TW-1:0] tag);
        ExpT e;
        int  sa;
        int  sb;
        e.tag = tag;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = '0;
            e.dbz = 1'b1;
        end else if (sgn && a == 16'h8000 && b == 8'hFF) begin
            e.q   = 16'h8000;
            e.r   = '0;
            e.ovf = 1'b1;
        end else if (sgn) begin
            sa  = $signed(a);
            sb  = $signed(b);
            e.q = N'(sa / sb);
            e.r = M'(sa % sb);
        end else begin
            e.q = a / N'(b);
            e.r = M'(a % N'(b));
        end
        return e;
    endfunction

    task automatic driveInputs(input logic sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                               input logic [TW-1:0] tag);
        inValid  = 1'b1;
        inSigned = sgn;
        dividend = a;
        divisor  = b;
        inTag    = tag;
    endtask

    // Presents one operation and pushes its expectation on the negedge before the accepting edge.
    task automatic applyStimulus(input logic sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                                 input logic [TW-1:0] tag, input ExpT e);
        bit accepted;
        accepted = 1'b0;
        @(posedge clock);
        #1;
        driveInputs(sgn, a, b, tag);
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (inReady) begin
                scoreQ.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) checkOutput("acceptTimeout", 32'(accepted), 1);
    endtask

    task automatic idleInput();
        @(posedge clock);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int c = 0; c < budget && scoreQ.size() != 0; c++) @(negedge clock);
        checkOutput("drainPending", 32'(scoreQ.size()), 0);
    endtask

    task automatic measureLatency(input string name);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (outValid) begin
                lat = c;
                break;
            end
        end
        checkOutput(name, 32'(lat), LAT);
    endtask

    // Scoreboard monitor: pops on every output handshake and checks results are held during stalls.
    logic        prevStall = 1'b0;
    logic [29:0] prevOut;
    always @(negedge clock) begin
        ExpT e;
        if (!resetN) begin
            scoreQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stallValid", 32'(outValid), 1);
                checkOutput("stallHold", 32'({quotient, remainder, dbz, ovf, outTag}), 32'(prevOut));
            end
            if (outValid && outReady) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpectedResult", 32'(scoreQ.size()), 1);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("quotient", 32'(quotient), 32'(e.q));
                    checkOutput("remainder", 32'(remainder), 32'(e.r));
                    checkOutput("dbz", 32'(dbz), 32'(e.dbz));
                    checkOutput("ovf", 32'(ovf), 32'(e.ovf));
                    checkOutput("tag", 32'(outTag), 32'(e.tag));
                end
            end
            prevStall = outValid && !outReady;
            prevOut   = {quotient, remainder, dbz, ovf, outTag};
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    VecT  vecs [NVEC];
    ExpT  fillExp [8];
    logic [N-1:0] fillA [8];
    logic [M-1:0] fillB [8];

    initial begin
        logic          sgn;
        logic [N-1:0]  a;
        logic [M-1:0]  b;
        int            sel;

        vecs[0]  = '{1'b0, 16'd1000, 8'd7,   4'd3,  '{16'd142,   8'd6,   1'b0, 1'b0, 4'd3}};
        vecs[1]  = '{1'b1, 16'hFF9C, 8'h07,  4'd1,  '{16'hFFF2,  8'hFE,  1'b0, 1'b0, 4'd1}};
        vecs[2]  = '{1'b1, 16'h0064, 8'hF9,  4'd2,  '{16'hFFF2,  8'h02,  1'b0, 1'b0, 4'd2}};
        vecs[3]  = '{1'b0, 16'd1234, 8'h00,  4'd4,  '{16'hFFFF,  8'h00,  1'b1, 1'b0, 4'd4}};
        vecs[4]  = '{1'b1, 16'd1234, 8'h00,  4'd5,  '{16'hFFFF,  8'h00,  1'b1, 1'b0, 4'd5}};
        vecs[5]  = '{1'b1, 16'h8000, 8'hFF,  4'd6,  '{16'h8000,  8'h00,  1'b0, 1'b1, 4'd6}};
        vecs[6]  = '{1'b1, 16'h8000, 8'h01,  4'd7,  '{16'h8000,  8'h00,  1'b0, 1'b0, 4'd7}};
        vecs[7]  = '{1'b0, 16'hFFFF, 8'hFF,  4'd8,  '{16'h0101,  8'h00,  1'b0, 1'b0, 4'd8}};
        vecs[8]  = '{1'b0, 16'h8000, 8'hFF,  4'd9,  '{16'd128,   8'h80,  1'b0, 1'b0, 4'd9}};
        vecs[9]  = '{1'b0, 16'd5,    8'd9,   4'd10, '{16'd0,     8'd5,   1'b0, 1'b0, 4'd10}};
        vecs[10] = '{1'b1, 16'hFF9C, 8'hF9,  4'd11, '{16'h000E,  8'hFE,  1'b0, 1'b0, 4'd11}};
        vecs[11] = '{1'b1, 16'h7FFF, 8'h80,  4'd12, '{16'hFF01,  8'h7F,  1'b0, 1'b0, 4'd12}};
        vecs[12] = '{1'b0, 16'hFFFF, 8'h01,  4'd13, '{16'hFFFF,  8'h00,  1'b0, 1'b0, 4'd13}};
        vecs[13] = '{1'b1, 16'h8000, 8'h80,  4'd14, '{16'h0100,  8'h00,  1'b0, 1'b0, 4'd14}};

        resetN = 1'b0; inValid = 1'b0; inSigned = 1'b0;
        dividend = '0; divisor = '0; inTag = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("resetOutValid", 32'(outValid), 0);
        checkOutput("resetQuotient", 32'(quotient), 0);
        checkOutput("resetRemainder", 32'(remainder), 0);
        checkOutput("resetDbz", 32'(dbz), 0);
        checkOutput("resetOvf", 32'(ovf), 0);
        checkOutput("resetTag", 32'(outTag), 0);
        checkOutput("resetInReady", 32'(inReady), 1);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
            idleInput();
            measureLatency("latency");
            waitDrain(20);
        end

        $display("[TB] random stream with backpressure");
        rndReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom());
            sel = $urandom_range(0, 9);
            b   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom());
            applyStimulus(sgn, a, b, 4'(i), refModel(sgn, a, b, 4'(i)));
        end
        idleInput();
        waitDrain(1000);
        rndReady = 1'b0;
        fixedReady = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] fill pipe and stall");
        for (int k = 0; k < 8; k++) begin
            fillA[k]   = 16'(1000 + k * 377);
            fillB[k]   = 8'(k + 3);
            fillExp[k] = refModel(1'b0, fillA[k], fillB[k], 4'(8 + k));
        end
        @(posedge clock);
        #1;
        fixedReady = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, fillA[k], fillB[k], 4'(8 + k), fillExp[k]);
        @(posedge clock);
        #1;
        driveInputs(1'b0, fillA[4], fillB[4], 4'(12));
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput("stallInReady", 32'(inReady), 0);
            checkOutput("stallFull", 32'(outValid), 1);
        end
        @(posedge clock);
        #1;
        fixedReady = 1'b1;
        for (int k = 4; k < 8; k++) begin
            @(negedge clock);
            checkOutput("releaseInReady", 32'(inReady), 1);
            checkOutput("releaseOutValid", 32'(outValid), 1);
            scoreQ.push_back(fillExp[k]);
            @(posedge clock);
            #1;
            if (k < 7) driveInputs(1'b0, fillA[k+1], fillB[k+1], 4'(8 + k + 1));
            else inValid = 1'b0;
        end
        waitDrain(20);

        $display("[TB] reset with operations in flight");
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 16'(16'hF000 + k), 8'h05, 4'(12 + k), refModel(1'b1, 16'(16'hF000 + k), 8'h05, 4'(12 + k)));
        @(posedge clock);
        #1;
        resetN = 1'b0;
        driveInputs(1'b0, 16'd999, 8'd3, 4'd15);
        @(negedge clock);
        checkOutput("inResetInReady", 32'(inReady), 1);
        @(posedge clock);
        #1;
        resetN  = 1'b1;
        inValid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checkOutput("flushedOutValid", 32'(outValid), 0);
        end
        applyStimulus(1'b0, 16'd3000, 8'd11, 4'd5, '{16'd272, 8'd8, 1'b0, 1'b0, 4'd5});
        idleInput();
        measureLatency("postResetLatency");
        waitDrain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
